// File: rtl/onewire_pkg.sv
// Shared types and constants for the single-wire byte link.
package onewire_pkg;

  localparam int FRAME_DATA_BITS = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START_CHK,
    RX_DATA,
    RX_STOP_CHK
  } rx_state_t;

  // Delay from a detected falling edge to the middle of the start bit.
  function automatic int half_slot(input int bit_ticks);
    return bit_ticks / 2;
  endfunction

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchroniser for the shared line, with a registered previous
// sample so a falling edge can be flagged for one cycle.
module onewire_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_line,
  output logic sync_q,
  output logic fall_pulse
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // The line idles high, so reset the chain high to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_line;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign sync_q     = r_sync;
  assign fall_pulse = r_prev & ~r_sync;

endmodule

// File: rtl/onewire_byte_link.sv
// Framed byte transceiver on an open-drain single-wire line (start, 8 data LSB
// first, stop). Optional collision abort when ONEWIRE_COLLISION_DETECT_EN is defined.
module onewire_byte_link
  import onewire_pkg::*;
#(
  parameter int BIT_TICKS = 5208,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
`ifdef ONEWIRE_COLLISION_DETECT_EN
  output logic       tx_collision,
`endif
  inout  wire        dinout
);

  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(half_slot(BIT_TICKS));
  localparam logic [2:0]       LAST_BIT  = 3'(FRAME_DATA_BITS - 1);

  tx_state_t        r_tx_state;
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_tx_bit;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_tx_sh;
  logic [7:0]       r_rx_sh;
  logic             r_drive_low;
  logic             r_tx_done;
  logic             r_rx_valid;
  logic             r_rx_err;
  logic [7:0]       r_rx_data;
  logic             r_wait_high;
`ifdef ONEWIRE_COLLISION_DETECT_EN
  logic             r_collision;
`endif

  logic w_sync_q;
  logic w_fall;
  logic w_tx_idle;
  logic w_busy;
  logic w_rx_arm;
  logic w_accept;

  onewire_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .i_line    (dinout),
    .sync_q    (w_sync_q),
    .fall_pulse(w_fall)
  );

  assign w_tx_idle = (r_tx_state == TX_IDLE);
  assign w_busy    = !w_tx_idle || (r_rx_state != RX_IDLE);
  // A receive start takes priority over a same-cycle transmit request.
  assign w_rx_arm  = (r_rx_state == RX_IDLE) && w_tx_idle && !r_wait_high && w_fall;
  assign w_accept  = tx_start && !w_busy && !w_rx_arm;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state  <= TX_IDLE;
      r_tx_cnt    <= '0;
      r_tx_bit    <= '0;
      r_drive_low <= 1'b0;
      r_tx_done   <= 1'b0;
`ifdef ONEWIRE_COLLISION_DETECT_EN
      r_collision <= 1'b0;
`endif
    end else begin
      r_tx_done <= 1'b0;
`ifdef ONEWIRE_COLLISION_DETECT_EN
      r_collision <= 1'b0;
`endif
      case (r_tx_state)
        TX_IDLE: begin
          if (w_accept) begin
            r_tx_sh     <= tx_data;
            r_tx_cnt    <= SLOT_LAST;
            r_drive_low <= 1'b1;
            r_tx_state  <= TX_START;
          end
        end
        TX_START: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt    <= SLOT_LAST;
            r_tx_bit    <= '0;
            r_drive_low <= ~r_tx_sh[0];
            r_tx_state  <= TX_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_DATA: begin
          if (r_tx_cnt == '0) begin
            r_tx_cnt <= SLOT_LAST;
            if (r_tx_bit == LAST_BIT) begin
              r_drive_low <= 1'b0;
              r_tx_state  <= TX_STOP;
            end else begin
              r_tx_bit    <= r_tx_bit + 1'b1;
              r_tx_sh     <= r_tx_sh >> 1;
              r_drive_low <= ~r_tx_sh[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        TX_STOP: begin
          if (r_tx_cnt == '0) begin
            r_tx_done  <= 1'b1;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt - 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
`ifdef ONEWIRE_COLLISION_DETECT_EN
      // Someone else holding the line low while we release it: abort the frame.
      if ((r_tx_state == TX_DATA || r_tx_state == TX_STOP) && !r_drive_low &&
          (r_tx_cnt == HALF_CNT) && !w_sync_q) begin
        r_drive_low <= 1'b0;
        r_collision <= 1'b1;
        r_tx_state  <= TX_IDLE;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_err    <= 1'b0;
      r_rx_data   <= 8'h00;
      r_wait_high <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (w_sync_q) r_wait_high <= 1'b0;
          if (w_rx_arm) begin
            r_rx_cnt   <= HALF_CNT;
            r_rx_state <= RX_START_CHK;
          end
        end
        RX_START_CHK: begin
          if (r_rx_cnt == '0) begin
            if (!w_sync_q) begin
              r_rx_cnt   <= SLOT_LAST;
              r_rx_bit   <= '0;
              r_rx_state <= RX_DATA;
            end else begin
              r_rx_state <= RX_IDLE;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == '0) begin
            r_rx_sh  <= {w_sync_q, r_rx_sh[7:1]};
            r_rx_cnt <= SLOT_LAST;
            if (r_rx_bit == LAST_BIT) r_rx_state <= RX_STOP_CHK;
            else                      r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        RX_STOP_CHK: begin
          if (r_rx_cnt == '0) begin
            r_rx_state <= RX_IDLE;
            if (w_sync_q) begin
              r_rx_data  <= r_rx_sh;
              r_rx_valid <= 1'b1;
            end else begin
              r_rx_err    <= 1'b1;
              r_wait_high <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign dinout   = r_drive_low ? 1'b0 : 1'bz;
  assign tx_busy  = w_busy;
  assign tx_done  = r_tx_done;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_err   = r_rx_err;
`ifdef ONEWIRE_COLLISION_DETECT_EN
  assign tx_collision = r_collision;
`endif

endmodule

// File: tb/tb_onewire_byte_link.sv
// Directed bench for onewire_byte_link with BIT_TICKS=16 and a pulled-up line.
`timescale 1ns/1ps
module tb_onewire_byte_link;

  localparam int BT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
`ifdef ONEWIRE_COLLISION_DETECT_EN
  logic       tx_collision;
`endif
  wire        dinout;
  logic       tb_low;

  int n_assert = 0;
  int n_fail   = 0;

  assign dinout = tb_low ? 1'b0 : 1'bz;
  pullup (dinout);

  always #5 clk = ~clk;

  onewire_byte_link #(.BIT_TICKS(BT), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_err      (rx_err),
`ifdef ONEWIRE_COLLISION_DETECT_EN
    .tx_collision(tx_collision),
`endif
    .dinout      (dinout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame from the bench side; optionally pulses tx_start mid-frame.
  task automatic drive_frame(input logic [7:0] d, input logic stop_bit, input int start_at,
                             output int nvalid, output int nerr, output int vcyc,
                             output int bad_line, output int busy_lo);
    logic [9:0] pat;
    pat = {stop_bit, d, 1'b0};
    nvalid = 0; nerr = 0; vcyc = -1; bad_line = 0; busy_lo = 0;
    for (int c = 0; c < 164; c++) begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin nvalid++; vcyc = c; end
      if (rx_err === 1'b1) begin nerr++; vcyc = c; end
      if (tb_low == 1'b0 && dinout !== 1'b1) bad_line++;
      if (c >= 4 && c < 150 && tx_busy !== 1'b1) busy_lo++;
      tx_start = (c == start_at);
      tx_data  = 8'h00;
      if (c < 160) tb_low = ~pat[c / BT];
      else         tb_low = ~stop_bit;
    end
    tx_start = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_a5;
    int nv, ne, vc, bl, bz;
    int early_done, busy_lo, cnt_a, cnt_b, cnt_c;

    exp_a5   = 10'b11_0100_1010;
    rst      = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    tb_low   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(tx_busy),  0);
    chk("rst_done",  32'(tx_done),  0);
    chk("rst_valid", 32'(rx_valid), 0);
    chk("rst_err",   32'(rx_err),   0);
    chk("rst_data",  32'(rx_data),  32'h00);
    chk("rst_line",  32'(dinout),   1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Transmit 8'hA5
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    early_done = 0; busy_lo = 0;
    for (int c = 0; c < 162; c++) begin
      @(negedge clk);
      if (c == 0) tx_start = 1'b0;
      if (c < 160 && (c % BT) == 8) chk("tx_a5_slot", 32'(dinout), 32'(exp_a5[c / BT]));
      if (c < 160 && tx_done !== 1'b0) early_done++;
      if (c < 160 && tx_busy !== 1'b1) busy_lo++;
      if (c == 160) chk("tx_done_at_160", 32'(tx_done), 1);
      if (c == 161) begin
        chk("tx_done_single", 32'(tx_done), 0);
        chk("tx_idle_after", 32'(tx_busy), 0);
      end
    end
    chk("tx_no_early_done", 32'(early_done), 0);
    chk("tx_busy_through", 32'(busy_lo), 0);
    repeat (10) @(negedge clk);

    // Receive 8'h3C
    drive_frame(8'h3C, 1'b1, -1, nv, ne, vc, bl, bz);
    chk("rx3c_valid_cnt", 32'(nv), 1);
    chk("rx3c_err_cnt", 32'(ne), 0);
    chk("rx3c_latency", 32'(vc >= 152 && vc <= 160), 1);
    chk("rx3c_data", 32'(rx_data), 32'h3C);
    chk("rx3c_busy", 32'(bz), 0);
    repeat (10) @(negedge clk);

    // Framing error: 8'hFF with stop held low, then line stays low
    drive_frame(8'hFF, 1'b0, -1, nv, ne, vc, bl, bz);
    chk("ferr_err_cnt", 32'(ne), 1);
    chk("ferr_valid_cnt", 32'(nv), 0);
    chk("ferr_hold_data", 32'(rx_data), 32'h3C);
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx_busy !== 1'b0) cnt_a++;
      if (rx_valid !== 1'b0 || rx_err !== 1'b0) cnt_b++;
    end
    chk("ferr_no_rearm_busy", 32'(cnt_a), 0);
    chk("ferr_no_rearm_pulse", 32'(cnt_b), 0);
    tb_low = 1'b0;
    repeat (20) @(negedge clk);
    drive_frame(8'h5A, 1'b1, -1, nv, ne, vc, bl, bz);
    chk("rearm_valid_cnt", 32'(nv), 1);
    chk("rearm_data", 32'(rx_data), 32'h5A);
    repeat (10) @(negedge clk);

    // Glitch: 4-cycle low pulse on an idle line
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx_busy === 1'b1) cnt_a++;
      if (rx_valid !== 1'b0) cnt_b++;
      if (rx_err !== 1'b0) cnt_c++;
      if (c == 0) tb_low = 1'b1;
      if (c == 4) tb_low = 1'b0;
    end
    chk("glitch_busy_window", 32'(cnt_a > 0 && cnt_a <= 11), 1);
    chk("glitch_no_valid", 32'(cnt_b), 0);
    chk("glitch_no_err", 32'(cnt_c), 0);
    chk("glitch_data_kept", 32'(rx_data), 32'h5A);
    repeat (10) @(negedge clk);

    // Contention: tx_start on the same cycle as the falling edge, then mid-frame
    drive_frame(8'hFF, 1'b1, 2, nv, ne, vc, bl, bz);
    chk("cont_same_cycle_line", 32'(bl), 0);
    chk("cont_same_cycle_data", 32'(rx_data), 32'hFF);
    drive_frame(8'h81, 1'b1, 40, nv, ne, vc, bl, bz);
    chk("cont_mid_line", 32'(bl), 0);
    chk("cont_mid_data", 32'(rx_data), 32'h81);
    cnt_a = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || dinout !== 1'b1) cnt_a++;
    end
    chk("cont_not_queued", 32'(cnt_a), 0);

    // Reset during transmit bit 3 of 8'h00
    tx_start = 1'b1;
    tx_data  = 8'h00;
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) tx_start = 1'b0;
      if (c == 68) chk("rst_mid_line_low", 32'(dinout), 0);
      if (c == 70) rst = 1'b1;
      if (c == 71) begin
        chk("rst_mid_line_rel", 32'(dinout), 1);
        chk("rst_mid_busy", 32'(tx_busy), 0);
        chk("rst_mid_done", 32'(tx_done), 0);
        chk("rst_mid_valid", 32'(rx_valid), 0);
        chk("rst_mid_err", 32'(rx_err), 0);
        chk("rst_mid_data", 32'(rx_data), 32'h00);
        rst = 1'b0;
      end
      if (c > 71 && tx_done !== 1'b0) cnt_a++;
      if (c > 71 && dinout !== 1'b1) cnt_b++;
    end
    chk("rst_mid_no_done", 32'(cnt_a), 0);
    chk("rst_mid_line_idle", 32'(cnt_b), 0);

`ifdef ONEWIRE_COLLISION_DETECT_EN
    // Collision: bench holds the line low during released data bit 1 of 8'hFF
    repeat (5) @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'hFF;
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) tx_start = 1'b0;
      if (tx_collision === 1'b1) cnt_a++;
      if (tx_done !== 1'b0) cnt_b++;
      if (c == 34) tb_low = 1'b1;
      if (c == 46) tb_low = 1'b0;
      if (c == 50) chk("coll_line_released", 32'(dinout), 1);
      if (c == 60) chk("coll_tx_idle", 32'(tx_busy), 0);
    end
    chk("coll_pulse_cnt", 32'(cnt_a), 1);
    chk("coll_no_done", 32'(cnt_b), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
